// File: rtl/bytes_screen_rx.sv
// Receive-side decoder for the bytes-screen debug protocol: finds tag-delimited
// frames in a UART byte stream, writes samples out and commits metadata per frame.
module bytes_screen_rx #(
  parameter  int TIMEOUT_CYCLES  = 500_000,
  parameter  int MAX_WIDTH       = 262_143,
  localparam int NUM_OSCILLATORS = 4,
  localparam int WW_WIDTH        = 18,
  localparam int SAMPLE_WIDTH    = 16
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic [7:0]                                byte_in,
  input  logic                                      byte_valid_in,
  output logic [WW_WIDTH-1:0]                       wave_width_out,
  output logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]  osc_indices_out,
  output logic [WW_WIDTH-1:0]                       sample_addr_out,
  output logic [SAMPLE_WIDTH-1:0]                   sample_data_out,
  output logic                                      sample_we_out,
  output logic                                      frame_active_out,
  output logic                                      frame_done_out,
  output logic                                      frame_error_out
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]   IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WW_WIDTH-1:0] MAX_W      = WW_WIDTH'(MAX_WIDTH);
  localparam logic [1:0]          LAST_OSC   = 2'(NUM_OSCILLATORS - 1);
  localparam logic [47:0] TAG_WID = "WAVWID";
  localparam logic [47:0] TAG_OSC = "OSCIDX";
  localparam logic [47:0] TAG_DAT = "WAVDAT";
  localparam logic [7:0]  CHAR_W  = 8'h57;

  typedef enum logic [2:0] {
    HUNT,
    WID_VAL,
    OSC_TAG,
    OSC_VAL,
    DAT_TAG,
    DAT_VAL
  } state_t;

  state_t state, state_n;

  logic [2:0]  tag_idx, tag_n;
  logic [1:0]  field_byte, field_byte_n;
  logic [1:0]  osc_num, osc_num_n;
  logic        phase, phase_n;
  logic [WW_WIDTH-1:0] sample_cnt, sample_cnt_n;
  logic [IDLE_W-1:0]   idle_cnt;

  logic [WW_WIDTH-1:0] shadow_w;
  logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0] shadow_osc;
  logic [7:0]  hi_byte;

  logic [47:0] tag_sel;
  logic [7:0]  exp_byte;
  logic        tag_match;
  logic        tag_last;
  logic [2:0]  restart_idx;
  logic [WW_WIDTH-1:0] width_dec;
  logic        do_err, do_commit, do_write;

  always_comb begin
    tag_sel = TAG_WID;
    if (state == OSC_TAG) begin
      tag_sel = TAG_OSC;
    end else if (state == DAT_TAG) begin
      tag_sel = TAG_DAT;
    end
    case (tag_idx)
      3'd0:    exp_byte = tag_sel[47:40];
      3'd1:    exp_byte = tag_sel[39:32];
      3'd2:    exp_byte = tag_sel[31:24];
      3'd3:    exp_byte = tag_sel[23:16];
      3'd4:    exp_byte = tag_sel[15:8];
      default: exp_byte = tag_sel[7:0];
    endcase
  end

  assign tag_match   = (byte_in == exp_byte);
  assign tag_last    = (tag_idx == 3'd5);
  assign restart_idx = (byte_in == CHAR_W) ? 3'd1 : 3'd0;
  assign width_dec   = {shadow_w[9:0], byte_in};

  always_comb begin
    state_n      = state;
    tag_n        = tag_idx;
    field_byte_n = field_byte;
    osc_num_n    = osc_num;
    phase_n      = phase;
    sample_cnt_n = sample_cnt;
    do_err       = 1'b0;
    do_commit    = 1'b0;
    do_write     = 1'b0;

    if (byte_valid_in) begin
      case (state)
        HUNT: begin
          if (!tag_match) begin
            tag_n = restart_idx;
          end else if (tag_last) begin
            state_n      = WID_VAL;
            tag_n        = 3'd0;
            field_byte_n = 2'd0;
          end else begin
            tag_n = tag_idx + 3'd1;
          end
        end
        WID_VAL: begin
          if (field_byte == 2'd2) begin
            field_byte_n = 2'd0;
            if (width_dec > MAX_W) begin
              do_err = 1'b1;
            end else begin
              state_n = OSC_TAG;
              tag_n   = 3'd0;
            end
          end else begin
            field_byte_n = field_byte + 2'd1;
          end
        end
        OSC_TAG: begin
          if (!tag_match) begin
            do_err = 1'b1;
          end else if (tag_last) begin
            state_n      = OSC_VAL;
            tag_n        = 3'd0;
            field_byte_n = 2'd0;
            osc_num_n    = 2'd0;
          end else begin
            tag_n = tag_idx + 3'd1;
          end
        end
        OSC_VAL: begin
          if (field_byte == 2'd2) begin
            field_byte_n = 2'd0;
            if (osc_num == LAST_OSC) begin
              state_n = DAT_TAG;
              tag_n   = 3'd0;
            end else begin
              osc_num_n = osc_num + 2'd1;
            end
          end else begin
            field_byte_n = field_byte + 2'd1;
          end
        end
        DAT_TAG: begin
          if (!tag_match) begin
            do_err = 1'b1;
          end else if (tag_last) begin
            tag_n = 3'd0;
            if (shadow_w == '0) begin
              state_n   = HUNT;
              do_commit = 1'b1;
            end else begin
              state_n      = DAT_VAL;
              phase_n      = 1'b0;
              sample_cnt_n = '0;
            end
          end else begin
            tag_n = tag_idx + 3'd1;
          end
        end
        DAT_VAL: begin
          if (!phase) begin
            phase_n = 1'b1;
          end else begin
            phase_n      = 1'b0;
            do_write     = 1'b1;
            sample_cnt_n = sample_cnt + WW_WIDTH'(1);
            if (sample_cnt == shadow_w - WW_WIDTH'(1)) begin
              state_n   = HUNT;
              tag_n     = 3'd0;
              do_commit = 1'b1;
            end
          end
        end
        default: begin
          state_n = HUNT;
          tag_n   = 3'd0;
        end
      endcase
    end else if (state != HUNT && idle_cnt == IDLE_LIMIT) begin
      do_err = 1'b1;
    end

    // A 'W' that breaks a frame may itself be the start of the next tag.
    if (do_err) begin
      state_n = HUNT;
      tag_n   = byte_valid_in ? restart_idx : 3'd0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= HUNT;
      tag_idx    <= 3'd0;
      field_byte <= 2'd0;
      osc_num    <= 2'd0;
      phase      <= 1'b0;
      sample_cnt <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_n;
      tag_idx    <= tag_n;
      field_byte <= field_byte_n;
      osc_num    <= osc_num_n;
      phase      <= phase_n;
      sample_cnt <= sample_cnt_n;
      if (byte_valid_in || state_n == HUNT) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  // Shadow registers collect the frame header so that commit is atomic.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow_w   <= '0;
      shadow_osc <= '0;
      hi_byte    <= 8'd0;
    end else if (byte_valid_in) begin
      if (state == WID_VAL) begin
        shadow_w <= width_dec;
      end
      if (state == OSC_VAL) begin
        shadow_osc[osc_num] <= {shadow_osc[osc_num][9:0], byte_in};
      end
      if (state == DAT_VAL && !phase) begin
        hi_byte <= byte_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wave_width_out  <= '0;
      osc_indices_out <= '0;
      sample_addr_out <= '0;
      sample_data_out <= '0;
      sample_we_out   <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      sample_we_out   <= do_write;
      frame_done_out  <= do_commit;
      frame_error_out <= do_err;
      if (do_write) begin
        sample_addr_out <= sample_cnt;
        sample_data_out <= {hi_byte, byte_in};
      end
      if (do_commit) begin
        wave_width_out  <= shadow_w;
        osc_indices_out <= shadow_osc;
      end
    end
  end

  assign frame_active_out = (state != HUNT);

endmodule

// File: doc/bytes_screen_rx.md
# bytes_screen_rx

Receive-side decoder for the bytes-screen debug protocol. It consumes the byte stream recovered by a UART receiver, one byte per `byte_valid_in` strobe, and locates frame boundaries by matching the ASCII tags. It decodes the wave width and the four oscillator indices, writes every wave sample into a sample buffer, and commits the frame's metadata atomically when the frame ends. It sits on the host-emulation or loopback side of the link, between `uart_receive` and a sample BRAM or display path.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 500_000: maximum number of idle clocks allowed between bytes inside a frame.
- `MAX_WIDTH`, default 262_143: largest accepted wave width.
- Fixed localparams: `NUM_OSCILLATORS`=4, `WW_WIDTH`=18, `SAMPLE_WIDTH`=16.

Ports:
- `clk_in`  in  1  system clock; the block uses this single clock.
- `rst_in`  in  1  reset, synchronous, active-high.
- `byte_in`  in  8  received byte.
- `byte_valid_in`  in  1  one-cycle strobe qualifying `byte_in`; back-to-back strobes are allowed.
- `wave_width_out`  out  18  committed wave width.
- `osc_indices_out`  out  [4][18]  committed oscillator indices.
- `sample_addr_out`  out  18  sample write address.
- `sample_data_out`  out  16  sample write data.
- `sample_we_out`  out  1  one-cycle sample write enable.
- `frame_active_out`  out  1  high whenever the FSM is in any state other than HUNT.
- `frame_done_out`  out  1  one-cycle pulse marking a good frame.
- `frame_error_out`  out  1  one-cycle pulse marking an aborted frame.

## Operation
Wire format, in byte order:
- "WAVWID" (57 41 56 57 49 44).
- Width: 3 bytes, most significant first: `{6'b0, w[17:16]}`, `w[15:8]`, `w[7:0]`.
- "OSCIDX".
- Oscillator indices 0 to 3: 3 bytes each, in the same byte order as the width.
- "WAVDAT".
- `w` samples, each 2 bytes, high byte first.

Byte handling:
- Only bytes qualified by `byte_valid_in` are consumed.
- The top 6 bits of each first 18-bit field byte are ignored.

States and transitions:
- HUNT: match "WAVWID" with a tag index 0..5.
  - On a mismatch, the tag index becomes 1 if the byte is 'W' (0x57), otherwise 0.
  - After the 6th byte matches, go to WID_VAL.
- WID_VAL: shift 3 bytes into the shadow width.
  - If the decoded width is greater than `MAX_WIDTH`, raise an error and go to HUNT.
  - Otherwise go to OSC_TAG.
- OSC_TAG: match "OSCIDX". Any mismatch raises an error; go to HUNT.
- OSC_VAL: 12 bytes.
  - Byte counter 0..11; the oscillator number is counter/3.
  - Bytes shift into shadow index registers.
  - Then go to DAT_TAG.
- DAT_TAG: match "WAVDAT". A mismatch raises an error.
  - If the shadow width is 0, commit and go to HUNT.
  - Otherwise go to DAT_VAL.
- DAT_VAL: a high/low byte toggle assembles each sample.
  - On every second byte, issue a write at address = sample count, then increment the count.
  - After sample `w-1`, commit and go to HUNT.

Error handling:
- An error pulses `frame_error_out` and returns the FSM to HUNT with the tag index cleared.
- When the offending byte is 'W', the tag index is 1 instead.
- Committed outputs stay unchanged on error.
- Samples already written during the aborted frame are not rolled back.

Commit:
- `wave_width_out` and `osc_indices_out` load from the shadow registers.
- `frame_done_out` pulses.

Timeout:
- An idle counter clears on every valid byte and counts while the FSM is not in HUNT.
- Reaching `TIMEOUT_CYCLES` is handled as an error.
- The counter does not run in HUNT.

## Timing
- Reset values: all outputs 0, FSM in HUNT, counters cleared.
- Reset asserted mid-frame abandons the frame without an error pulse.
- Outputs are registered. `sample_we_out` is high for exactly the cycle after the second byte of a sample is accepted, with address and data valid in that same cycle.
- `frame_done_out` is high in the cycle after the last byte of the frame is accepted.
  - For a nonzero width, this is the same cycle as the final `sample_we_out`.
  - Committed outputs show the new values in that cycle.
- `frame_error_out` is high in the cycle after the offending byte is accepted, or after the timeout is reached.
- A valid byte in the same cycle the timeout is reached takes priority: the counter clears and no error is raised.
- A new frame's tag bytes can start on the very next cycle after a commit or an error.
- There is no backpressure. The block must accept one byte every cycle indefinitely.

## Test plan
- Clean frame, width 3, indices 0x00001/0x3FFFF/0x12345/0x00000, samples 0x1234/0xABCD/0x0001 sent back-to-back:
  - writes (0,0x1234), (1,0xABCD), (2,0x0001);
  - `frame_done_out` pulses once and coincides with the write at address 2;
  - outputs commit to 3 and to those indices.
- Leading garbage "X W W A V W I D ..." followed by a valid width-1 frame: the decoder resyncs on the second 'W' and the frame completes normally.
- Tag "OSCIDY" corrupted at its final byte: `frame_error_out` pulses one cycle after the 'Y'; committed outputs keep their previous values; `sample_we_out` never asserts.
- Width 0 frame: `frame_done_out` pulses after the final 'T' with no writes, and `wave_width_out` becomes 0. Width 0x3FFFF with `MAX_WIDTH`=1000: `frame_error_out` pulses after the third width byte.
- With `TIMEOUT_CYCLES`=50, stall for 50 cycles after the first byte of the second sample: `frame_error_out` pulses and the FSM returns to HUNT; a stall of 49 cycles produces no error.
- `rst_in` asserted for one cycle mid-DAT_VAL: all outputs return to 0 with no error pulse; a following clean frame decodes correctly from address 0.
